// File: rtl/alpu_cache_client.sv
// alpu_cache_client: requester-side controller for the ALPU operand cache port.
// Accepts one read/write request at a time, issues it to the cache with a
// bounded number of retries, and returns data/completion plus an error flag.
module alpu_cache_client #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_RETRY  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_we_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  output logic                  cache_ce_o,
  output logic                  cache_we_o,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  input  logic                  cache_rvalid_i,
  input  logic                  cache_wack_i,
  output logic [15:0]           stat_retry_o
);

  localparam int unsigned CW = $clog2(MAX_RETRY) + 1;
  localparam logic [CW-1:0] LAST_ATTEMPT = CW'(MAX_RETRY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic [CW-1:0]         attempt;
  logic [15:0]           stat;

  logic accept;
  logic qual;
  logic hit;
  logic miss;
  logic give_up;

  // Handshake and qualifier decode; next-state selection
  always_comb begin
    state_next = state;
    accept     = (state == IDLE) && req_valid_i;
    qual       = we ? cache_wack_i : cache_rvalid_i;
    hit        = (state == ISSUE) && qual;
    miss       = (state == ISSUE) && !qual;
    give_up    = miss && (attempt == LAST_ATTEMPT);
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (hit || give_up) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request latch, attempt counter and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      attempt <= '0;
    end else if (accept) begin
      we      <= req_we_i;
      addr    <= req_addr_i;
      wdata   <= req_wdata_i;
      attempt <= '0;
    end else if (hit) begin
      rdata <= we ? '0 : cache_rdata_i;
      err   <= 1'b0;
    end else if (give_up) begin
      rdata <= '0;
      err   <= 1'b1;
    end else if (miss) begin
      attempt <= attempt + 1'b1;
    end
  end

  // Saturating count of refused attempts
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    stat <= '0;
    else if (miss && stat != '1)  stat <= stat + 16'd1;
  end

  // Outputs are decoded from registered state and holding fields only
  assign req_ready_o   = (state == IDLE);
  assign rsp_valid_o   = (state == RESP);
  assign rsp_rdata_o   = rdata;
  assign rsp_we_o      = we;
  assign rsp_err_o     = err;
  assign cache_ce_o    = (state == ISSUE);
  assign cache_we_o    = (state == ISSUE) && we;
  assign cache_addr_o  = addr;
  assign cache_wdata_o = wdata;
  assign stat_retry_o  = stat;

endmodule

// File: tb/tb_alpu_cache_client.sv
// Self-checking bench for alpu_cache_client: directed test-plan scenarios and
// randomized requests against a transaction-level model, plus a second
// instance with a very large retry budget to drive the statistics counter
// into saturation.
module tb_alpu_cache_client;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 8;
  localparam int unsigned MAXR = 4;
  localparam int unsigned SATR = 65600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_stat = 0;
  bit          sat_done = 1'b0;

  // main instance
  logic          reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr, cache_addr;
  logic [DW-1:0] req_wdata, rsp_rdata, cache_wdata, cache_rdata;
  logic          rsp_we, rsp_err, cache_ce, cache_we, cache_rvalid, cache_wack;
  logic [15:0]   stat_retry;

  alpu_cache_client #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_we_o(rsp_we), .rsp_err_o(rsp_err),
    .cache_addr_o(cache_addr), .cache_wdata_o(cache_wdata),
    .cache_ce_o(cache_ce), .cache_we_o(cache_we),
    .cache_rdata_i(cache_rdata), .cache_rvalid_i(cache_rvalid),
    .cache_wack_i(cache_wack), .stat_retry_o(stat_retry)
  );

  // saturation instance
  logic          s_reset, s_req_valid, s_req_ready, s_req_we, s_rsp_valid, s_rsp_ready;
  logic [AW-1:0] s_req_addr, s_cache_addr;
  logic [DW-1:0] s_req_wdata, s_rsp_rdata, s_cache_wdata, s_cache_rdata;
  logic          s_rsp_we, s_rsp_err, s_cache_ce, s_cache_we, s_cache_rvalid, s_cache_wack;
  logic [15:0]   s_stat_retry;

  alpu_cache_client #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_RETRY(SATR)) dut_sat (
    .clk(clk), .reset(s_reset),
    .req_valid_i(s_req_valid), .req_ready_o(s_req_ready), .req_we_i(s_req_we),
    .req_addr_i(s_req_addr), .req_wdata_i(s_req_wdata),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(s_rsp_ready), .rsp_rdata_o(s_rsp_rdata),
    .rsp_we_o(s_rsp_we), .rsp_err_o(s_rsp_err),
    .cache_addr_o(s_cache_addr), .cache_wdata_o(s_cache_wdata),
    .cache_ce_o(s_cache_ce), .cache_we_o(s_cache_we),
    .cache_rdata_i(s_cache_rdata), .cache_rvalid_i(s_cache_rvalid),
    .cache_wack_i(s_cache_wack), .stat_retry_o(s_stat_retry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request. refuse = number of refused attempts before the
  // qualifier rises; refuse >= MAXR means the cache never answers.
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int unsigned refuse,
                        input int unsigned stall, input bit poke);
    bit            exp_err;
    int unsigned   attempts;
    logic [DW-1:0] exp_rdata;
    exp_err   = (refuse >= MAXR);
    attempts  = exp_err ? MAXR : refuse + 1;
    exp_rdata = (!w && !exp_err) ? rd : '0;

    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = wd;
    rsp_ready = (stall == 0);
    @(posedge clk);
    for (int unsigned i = 0; i < attempts; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      req_we    = 1'($urandom_range(0, 1));
      chk("issue_ce", {31'd0, cache_ce}, 32'd1);
      chk("issue_we", {31'd0, cache_we}, {31'd0, w});
      chk("issue_addr", {24'd0, cache_addr}, {24'd0, a});
      chk("issue_wdata", {16'd0, cache_wdata}, {16'd0, wd});
      if (w) begin
        cache_wack   = (i == refuse);
        cache_rvalid = 1'($urandom_range(0, 1));
      end else begin
        cache_rvalid = (i == refuse);
        cache_wack   = 1'($urandom_range(0, 1));
      end
      cache_rdata = (i == refuse) ? rd : DW'($urandom);
      @(posedge clk);
    end
    exp_stat = exp_stat + (exp_err ? MAXR : refuse);
    if (exp_stat > 32'hFFFF) exp_stat = 32'hFFFF;

    @(negedge clk);
    req_valid    = poke;
    req_addr     = AW'($urandom);
    cache_rvalid = 1'b1;
    cache_wack   = 1'b1;
    cache_rdata  = DW'($urandom);
    chk("resp_ce_off", {31'd0, cache_ce}, 32'd0);
    chk("resp_we_off", {31'd0, cache_we}, 32'd0);
    chk("resp_addr_hold", {24'd0, cache_addr}, {24'd0, a});
    chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
    chk("resp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    chk("resp_we", {31'd0, rsp_we}, {31'd0, w});
    chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
    chk("stat", {16'd0, stat_retry}, exp_stat);
    for (int unsigned s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
      chk("stall_err", {31'd0, rsp_err}, {31'd0, exp_err});
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_ce", {31'd0, cache_ce}, 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    chk("post_ce", {31'd0, cache_ce}, 32'd0);
    cache_rvalid = 1'b0;
    cache_wack   = 1'b0;
  endtask

  // Main sequence
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; cache_rdata = '0; cache_rvalid = 1'b1; cache_wack = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_we", {31'd0, rsp_we}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_ce", {31'd0, cache_ce}, 32'd0);
    chk("rst_cache_we", {31'd0, cache_we}, 32'd0);
    chk("rst_addr", {24'd0, cache_addr}, 32'd0);
    chk("rst_wdata", {16'd0, cache_wdata}, 32'd0);
    chk("rst_stat", {16'd0, stat_retry}, 32'd0);
    reset = 1'b0;
    cache_rvalid = 1'b0; cache_wack = 1'b0;

    // read hit, write retry, retry exhaustion, backpressure
    do_req(1'b0, 8'h12, 16'h0000, 16'hBEEF, 0, 0, 1'b0);
    do_req(1'b1, 8'h34, 16'h00A5, 16'h1234, 1, 0, 1'b0);
    do_req(1'b0, 8'h56, 16'h0000, 16'h7777, MAXR, 0, 1'b0);
    do_req(1'b0, 8'h78, 16'h0000, 16'hCAFE, 0, 5, 1'b1);
    // accept straight after a retried read handshake, boundary refusal count
    do_req(1'b0, 8'hFF, 16'h0000, 16'h0001, MAXR - 1, 0, 1'b0);

    // reset during the 2nd retry
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h9A; rsp_ready = 1'b1;
    @(posedge clk);
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 1'b0; cache_rvalid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    chk("mid_ce_before", {31'd0, cache_ce}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_ce_async", {31'd0, cache_ce}, 32'd0);
    chk("mid_rsp_async", {31'd0, rsp_valid}, 32'd0);
    chk("mid_stat", {16'd0, stat_retry}, 32'd0);
    chk("mid_addr", {24'd0, cache_addr}, 32'd0);
    exp_stat = 0;
    @(negedge clk);
    reset = 1'b0;
    cache_rvalid = 1'b1; cache_wack = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_no_ce", {31'd0, cache_ce}, 32'd0);
    end
    cache_rvalid = 1'b0; cache_wack = 1'b0;
    do_req(1'b0, 8'h21, 16'h0000, 16'h5A5A, 0, 0, 1'b0);

    // randomized traffic against the transaction model
    for (int unsigned n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), DW'($urandom),
             $urandom_range(0, MAXR), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    for (int unsigned i = 0; i < 80000 && !sat_done; i++) @(negedge clk);
    chk("sat_done", {31'd0, sat_done}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Saturation: one read that is refused SATR times in a row
  initial begin
    s_reset = 1'b1; s_req_valid = 1'b0; s_req_we = 1'b0; s_req_addr = '0;
    s_req_wdata = '0; s_rsp_ready = 1'b1; s_cache_rdata = 16'hFFFF;
    s_cache_rvalid = 1'b0; s_cache_wack = 1'b1;
    repeat (2) @(negedge clk);
    s_reset = 1'b0;
    @(negedge clk);
    s_req_valid = 1'b1; s_req_addr = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    s_req_valid = 1'b0;
    for (int unsigned k = 1; k <= SATR; k++) begin
      if (s_cache_ce !== 1'b1) begin
        chk("sat_ce", {31'd0, s_cache_ce}, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
      if (k == 65534) chk("sat_fffe", {16'd0, s_stat_retry}, 32'h0000FFFE);
      if (k == 65535) chk("sat_ffff", {16'd0, s_stat_retry}, 32'h0000FFFF);
      if (k == 65536) chk("sat_nowrap", {16'd0, s_stat_retry}, 32'h0000FFFF);
      @(negedge clk);
    end
    chk("sat_rsp_valid", {31'd0, s_rsp_valid}, 32'd1);
    chk("sat_rsp_err", {31'd0, s_rsp_err}, 32'd1);
    chk("sat_rsp_rdata", {16'd0, s_rsp_rdata}, 32'd0);
    chk("sat_final", {16'd0, s_stat_retry}, 32'h0000FFFF);
    sat_done = 1'b1;
  end

endmodule
